// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line-level bit constants
// used by both the receive and transmit sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/rx_data_sampler.sv
// Captures RX_IN three times around the bit centre and majority-votes the
// result; the vote stays valid until the next bit's first capture.
module rx_data_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sample_done
);

    logic [PRESCALE_W-1:0] half;
    logic [2:0]            samples_q;
    logic [2:0]            samples_d;

    assign half = PRESCALE >> 1;

    always_comb begin
        samples_d = samples_q;
        if (edge_cnt == half - 1'b1) begin
            samples_d[0] = RX_IN;
        end
        if (edge_cnt == half) begin
            samples_d[1] = RX_IN;
        end
        if (edge_cnt == half + 1'b1) begin
            samples_d[2] = RX_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samples_q <= 3'b111;
        end else begin
            samples_q <= samples_d;
        end
    end

    assign sampled_bit = (samples_q[0] & samples_q[1]) |
                         (samples_q[0] & samples_q[2]) |
                         (samples_q[1] & samples_q[2]);
    assign sample_done = (edge_cnt == half + PRESCALE_W'(2));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, LSB-first deserialisation,
// optional parity and stop-bit checks with one-cycle result strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int PRESCALE_W  = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic [PRESCALE_W-1:0]  PRESCALE,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    output logic [DATA_LENGTH-1:0] P_DATA,
    output logic                   DATA_VALID,
    output logic                   PAR_ERR,
    output logic                   STP_ERR
);

    localparam int BW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

    uart_state_t            state_q, state_d;
    logic [PRESCALE_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_LENGTH-1:0] shift_q, shift_d;
    logic [DATA_LENGTH-1:0] p_data_q, p_data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   par_err_q, par_err_d;
    logic                   stp_err_q, stp_err_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic                   par_bad_q, par_bad_d;
    logic                   sampled_bit;
    logic                   sample_done;
    logic                   bit_end;

    rx_data_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PRESCALE    (PRESCALE),
        .edge_cnt    (edge_cnt_q),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done)
    );

    assign bit_end = (edge_cnt_q == PRESCALE - 1'b1);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = (state_q == IDLE || bit_end) ? '0 : edge_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;

        case (state_q)
            IDLE: begin
                if (RX_IN == START_BIT) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                // A start bit that does not survive the vote was line noise
                if (sample_done && sampled_bit != START_BIT) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {sampled_bit, shift_q[DATA_LENGTH-1:1]};
                    if (bit_cnt_q == BW'(DATA_LENGTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_bad_d = sampled_bit != (^shift_q ^ (par_typ_q == PAR_ODD));
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stp_err_d = (sampled_bit != STOP_BIT);
                    par_err_d = par_bad_q;
                    if (sampled_bit == STOP_BIT && !par_bad_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    // A low line here is the next frame's start bit
                    if (RX_IN == START_BIT) begin
                        state_d   = START;
                        par_en_d  = PAR_EN;
                        par_typ_d = PAR_TYP;
                        par_bad_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            par_bad_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the team's UART transmitter. Uses the same frame format: start bit (0), DATA_LENGTH data bits LSB-first, optional parity bit, stop bit (1).
- Runs on an oversampling clock: CLK = PRESCALE x baud.
- Majority-votes three samples per bit, checks parity and stop bit, and presents the deserialised word with a one-cycle valid strobe.
- Sits between the RX pad synchroniser and the system-side register/FIFO logic.

Parameters:
- DATA_LENGTH, 8, number of data bits per frame
- PRESCALE_W, 6, width of the PRESCALE input (supports oversampling up to 32)

Ports:
- CLK  input  1  oversampling clock (PRESCALE x baud)
- RST  input  1  asynchronous active-low reset
- RX_IN  input  1  serial line, already synchronised to CLK, idle high
- PRESCALE  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32; must be static while a frame is in flight
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- P_DATA  output  DATA_LENGTH  last correctly received word
- DATA_VALID  output  1  one-cycle strobe: P_DATA updated with a good frame
- PAR_ERR  output  1  one-cycle strobe: parity mismatch
- STP_ERR  output  1  one-cycle strobe: stop bit sampled 0

Behaviour:
- Reset (RST=0, asynchronous): FSM=IDLE; edge_cnt=0; bit_cnt=0; shift register=0; P_DATA=0; DATA_VALID=0; PAR_ERR=0; STP_ERR=0. Reset mid-frame abandons the frame with no strobe.
- edge_cnt runs 0..PRESCALE-1 in every non-IDLE state and wraps to 0 at PRESCALE-1. bit_cnt counts data bits 0..DATA_LENGTH-1.
- Sampling: RX_IN is captured at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The sampled bit is the 2-of-3 majority, valid from edge_cnt = PRESCALE/2+2.
- FSM states:
  - IDLE: RX_IN=0 -> START with edge_cnt=0.
  - START: if the sampled bit is 1, the start was a glitch: return to IDLE immediately, with no strobe. Otherwise, at edge_cnt = PRESCALE-1 -> DATA.
  - DATA: at each bit end, shift the sampled bit in LSB-first. After bit DATA_LENGTH-1 -> PARITY if PAR_EN=1, else STOP.
  - PARITY: expected bit = XOR(data) ^ PAR_TYP. Record whether it mismatches; at bit end -> STOP.
  - STOP: at edge_cnt = PRESCALE-1, evaluate the frame:
    - good frame (stop=1 and no parity error): load P_DATA and pulse DATA_VALID.
    - parity error: pulse PAR_ERR; P_DATA unchanged.
    - stop bit 0: pulse STP_ERR; P_DATA unchanged.
    - Both errors may pulse in the same cycle.
  - Leaving STOP: go to START if RX_IN=0 on that cycle (back-to-back frame), else IDLE.
- Strobes are registered and high for exactly one CLK cycle, the cycle after the stop-bit end edge.
- Latency from the stop-bit start edge to DATA_VALID is PRESCALE cycles.
- PAR_EN and PAR_TYP are sampled at frame start (IDLE->START) and held for the rest of the frame.
- A PRESCALE value outside {8, 16, 32} gives undefined results; no checking is done.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding typedef (IDLE, START, DATA, PARITY, STOP), shared with the TX FSM encoding style
  - constants START_BIT=1'b0, STOP_BIT=1'b1, PAR_EVEN=1'b0, PAR_ODD=1'b1
- One natural sub-module: rx_data_sampler, containing the edge counter compare, the three sample registers and the majority vote. Its outputs are sampled_bit and sample_done.
- The FSM, deserialiser and checks stay in uart_rx.

Test Plan:
1. PRESCALE=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0, stop 1 -> DATA_VALID pulses once, P_DATA=0xA5, PAR_ERR=0, STP_ERR=0.
2. PRESCALE=16, PAR_EN=0, two back-to-back frames 0x3C then 0xFF with no idle gap -> two DATA_VALID pulses exactly 10x16 cycles apart; P_DATA=0x3C, then 0xFF.
3. PRESCALE=8, PAR_EN=1, PAR_TYP=1, frame 0x0F sent with parity bit 0 -> PAR_ERR pulses one cycle; DATA_VALID=0; P_DATA keeps its previous value.
4. PRESCALE=32, PAR_EN=0, frame 0x81 with stop bit 0 -> STP_ERR pulses one cycle; no DATA_VALID. A following good frame 0x55 is received correctly.
5. PRESCALE=8, RX_IN low for 2 cycles then high (glitch) -> FSM back in IDLE, all strobes 0. A subsequent frame 0x12 is received correctly.
6. PRESCALE=8, RST asserted during data bit 4 of frame 0xC3 -> all outputs 0 immediately, no strobe. The next full frame 0x7E gives DATA_VALID with P_DATA=0x7E.
7. Majority check: one-cycle inverted spike at the centre sample of every data bit of 0x96 -> P_DATA=0x96.
